lfsr_rand_server: RTL and testbench
===================================

// Module: lfsr_rand_server
// PURPOSE
//  Shares one 5-bit internal-XOR LFSR (x^5+x^2+1, period 31) between NUM_REQ requesters.
//  Round-robin arbitration; one registered grant per cycle, carrying a fresh random value.
//  Handles seeding, lockup avoidance and a post-seed warm-up window.
//  Sits between the pseudo-random sources and their consumers (test-pattern and stall-injection logic).
// PARAMETERS
//  NUM_REQ        4        number of requesters, 2..8
//  SEED           5'h01    LFSR value at reset; 5'h00 is replaced by 5'h01
//  WARMUP_CYCLES  4        LFSR steps after reset or seed load before grants start, 1..31
// PORTS
//  clk         in   1        single clock, rising edge
//  rst         in   1        one clock; reset is synchronous and active-high
//  seed_load   in   1        load seed_in into LFSR and restart warm-up
//  seed_in     in   5        new seed; 5'h00 is replaced by 5'h01
//  req         in   NUM_REQ  level request, one bit per requester
//  gnt         out  NUM_REQ  one-hot, single-cycle grant pulse
//  rand_valid  out  1        high with any gnt bit
//  rand_out    out  5        random value for the granted requester; valid when rand_valid
//  busy        out  1        high while in WARMUP
// BEHAVIOUR
//  - LFSR next state: n[0]=s[4], n[1]=s[0], n[2]=s[1]^s[4], n[3]=s[2], n[4]=s[3].
//  - Reset values:
//      LFSR = SEED (5'h00 -> 5'h01), state = WARMUP, warm_cnt = 0, rr_ptr = 0
//      gnt = 0, rand_valid = 0, rand_out = 0, busy = 1
//  - FSM states: WARMUP, RUN.
//  - WARMUP:
//      LFSR steps every cycle; warm_cnt increments; no grants; busy = 1.
//      After exactly WARMUP_CYCLES steps: state -> RUN, warm_cnt cleared, busy = 0 next cycle.
//  - RUN: LFSR steps only on the cycle a grant is issued.
//  - Arbitration, in RUN at cycle t:
//      eligible = req & ~gnt. A requester holding gnt at t is masked, so req held one extra cycle
//      does not cause a double grant.
//      Winner = first eligible index searching upward from rr_ptr, with wrap-around.
//      At t+1: gnt[winner] = 1, rand_valid = 1, rand_out = LFSR value at t.
//      At t the LFSR steps and rr_ptr = (winner+1) mod NUM_REQ.
//      No eligible requester: gnt = 0, rand_valid = 0, rand_out holds its value, LFSR holds.
//  - Latency: 1 cycle from req to gnt. Back-to-back grants to different requesters every cycle.
//  - A single requester holding req gets a grant every other cycle.
//  - seed_load, any state:
//      Wins over req in the same cycle; no grant is issued at t+1.
//      LFSR = seed_in (or 5'h01 if zero), state -> WARMUP, warm_cnt = 0.
//      rr_ptr is kept. A gnt pulse already registered still completes in the load cycle.
//  - seed_load during WARMUP restarts the warm-up count.
//  - rst has priority over everything. Mid-operation it clears all state; no partial grant is emitted.
//  - The LFSR never reaches 5'h00. rand_out is never 5'h00 while rand_valid = 1.
// TESTING
//  T1 reset, SEED=1, WARMUP=4:
//     busy high 4 cycles; LFSR 01->02->04->08->10; busy low on the 5th cycle.
//  T2 after T1, req=4'b0001 for 1 cycle:
//     next cycle gnt=4'b0001, rand_valid=1, rand_out=5'h10; LFSR -> 5'h05.
//  T3 req=4'b1111 held, rr_ptr=0:
//     gnts 0001,0010,0100,1000,0001 on consecutive cycles; rand_out values are successive LFSR states.
//  T4 seed_load=1 with seed_in=0 and req=4'b0010:
//     no gnt next cycle; LFSR=5'h01; busy=1 for 4 cycles.
//  T5 req[2] held alone in RUN: gnt[2] pulses on alternate cycles, never two in a row.
//  T6 rst=1 during back-to-back grants:
//     next cycle gnt=0, rand_valid=0, rand_out=0, busy=1; 31 consecutive grants visit all nonzero values.

Source files
------------

// File: rtl/lfsr_rand_server.sv
// lfsr_rand_server: one 5-bit Galois LFSR (x^5+x^2+1, period 31) shared by NUM_REQ
// requesters through a round-robin arbiter. Each grant is a registered one-cycle pulse
// that carries the current LFSR value, after which the LFSR advances.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   seed_load   load seed_in into the LFSR and restart warm-up
//   seed_in     new seed (zero is replaced by 5'h01)
//   req         level requests, one bit per requester
//   gnt         one-hot single-cycle grant pulse
//   rand_valid  high together with any gnt bit
//   rand_out    random value for the granted requester
//   busy        high while warming up

module lfsr_rand_server #(
   parameter int unsigned NUM_REQ       = 4,
   parameter logic [4:0]  SEED          = 5'h01,
   parameter int unsigned WARMUP_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seed_load,
   input  logic [4:0]         seed_in,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic               rand_valid,
   output logic [4:0]         rand_out,
   output logic               busy
);

   localparam int unsigned PtrW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [4:0]  SeedInit = (SEED == 5'h00) ? 5'h01 : SEED;
   localparam logic [4:0]  WarmLast = 5'(WARMUP_CYCLES - 1);

   typedef enum logic [0:0] {StWarmup, StRun} state_e;

   state_e             state_q, state_d;
   logic [4:0]         lfsr_q, lfsr_d;
   logic [4:0]         warm_cnt_q, warm_cnt_d;
   logic [PtrW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               rand_valid_q, rand_valid_d;
   logic [4:0]         rand_out_q, rand_out_d;

   logic [NUM_REQ-1:0] eligible;
   logic               found;
   logic [PtrW-1:0]    winner;

   function automatic logic [4:0] lfsr_step(input logic [4:0] s);
      return {s[3], s[2], s[1] ^ s[4], s[0], s[4]};
   endfunction

   // Round-robin search starting at rr_ptr; the requester granted last cycle is masked
   // so a request held one extra cycle is not granted twice.
   always_comb begin
      eligible = req & ~gnt_q;
      found    = 1'b0;
      winner   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         int unsigned     idx;
         logic [PtrW-1:0] cand;
         idx  = (32'(rr_ptr_q) + i) % NUM_REQ;
         cand = PtrW'(idx);
         if (!found && eligible[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_q;
      warm_cnt_d   = warm_cnt_q;
      rr_ptr_d     = rr_ptr_q;
      gnt_d        = '0;
      rand_valid_d = 1'b0;
      rand_out_d   = rand_out_q;

      if (seed_load) begin
         // Seeding pre-empts arbitration; rr_ptr survives the reload.
         lfsr_d     = (seed_in == 5'h00) ? 5'h01 : seed_in;
         state_d    = StWarmup;
         warm_cnt_d = '0;
      end else begin
         unique case (state_q)
            StWarmup: begin
               lfsr_d = lfsr_step(lfsr_q);
               if (warm_cnt_q == WarmLast) begin
                  state_d    = StRun;
                  warm_cnt_d = '0;
               end else begin
                  warm_cnt_d = warm_cnt_q + 5'd1;
               end
            end
            StRun: begin
               if (found) begin
                  gnt_d[winner] = 1'b1;
                  rand_valid_d  = 1'b1;
                  rand_out_d    = lfsr_q;
                  lfsr_d        = lfsr_step(lfsr_q);
                  rr_ptr_d      = PtrW'((32'(winner) + 32'd1) % NUM_REQ);
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StWarmup;
         lfsr_q       <= SeedInit;
         warm_cnt_q   <= '0;
         rr_ptr_q     <= '0;
         gnt_q        <= '0;
         rand_valid_q <= 1'b0;
         rand_out_q   <= '0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         warm_cnt_q   <= warm_cnt_d;
         rr_ptr_q     <= rr_ptr_d;
         gnt_q        <= gnt_d;
         rand_valid_q <= rand_valid_d;
         rand_out_q   <= rand_out_d;
      end
   end

   assign gnt        = gnt_q;
   assign rand_valid = rand_valid_q;
   assign rand_out   = rand_out_q;
   assign busy       = (state_q == StWarmup);

endmodule

// File: tb/tb_lfsr_rand_server.sv
// tb_lfsr_rand_server: directed and randomized bench for lfsr_rand_server with a
// behavioural model (LFSR as multiplication by x in GF(2^5) mod x^5+x^2+1).

module tb_lfsr_rand_server;

   logic       clk = 1'b0;
   logic       rst;
   logic       seed_load;
   logic [4:0] seed_in;
   logic [3:0] req;
   logic [3:0] gnt;
   logic       rand_valid;
   logic [4:0] rand_out;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Model state
   logic [4:0] m_lfsr;
   logic [4:0] m_out;
   logic [3:0] m_gnt;
   logic       m_valid;
   bit         m_warm;
   int         m_cnt;
   int         m_ptr;

   localparam int Warm = 4;

   lfsr_rand_server #(
      .NUM_REQ       (4),
      .SEED          (5'h01),
      .WARMUP_CYCLES (Warm)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .seed_load  (seed_load),
      .seed_in    (seed_in),
      .req        (req),
      .gnt        (gnt),
      .rand_valid (rand_valid),
      .rand_out   (rand_out),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] mul_x(input logic [4:0] v);
      int t;
      t = int'(v) * 2;
      if (t >= 32) t = t ^ 37;
      return 5'(t);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic sl, input logic [4:0] si,
                             input logic [3:0] rq);
      logic [3:0] ng;
      logic       nv;
      logic [3:0] elig;
      bit         hit;
      if (r) begin
         m_lfsr = 5'h01; m_warm = 1; m_cnt = 0; m_ptr = 0;
         m_gnt = '0; m_valid = 0; m_out = '0;
      end else begin
         ng = '0;
         nv = 0;
         if (sl) begin
            m_lfsr = (si == 5'h00) ? 5'h01 : si;
            m_warm = 1;
            m_cnt  = 0;
         end else if (m_warm) begin
            m_lfsr = mul_x(m_lfsr);
            m_cnt++;
            if (m_cnt == Warm) begin
               m_warm = 0;
               m_cnt  = 0;
            end
         end else begin
            elig = rq & ~m_gnt;
            hit  = 0;
            for (int k = 0; k < 4; k++) begin
               int idx;
               idx = (m_ptr + k) % 4;
               if (!hit && elig[idx]) begin
                  hit     = 1;
                  ng[idx] = 1'b1;
                  nv      = 1'b1;
                  m_out   = m_lfsr;
                  m_lfsr  = mul_x(m_lfsr);
                  m_ptr   = (idx + 1) % 4;
               end
            end
         end
         m_gnt   = ng;
         m_valid = nv;
      end
   endtask

   // One clock: drive, advance model, sample 1 time unit after the edge, compare.
   task automatic cyc(input logic r, input logic sl, input logic [4:0] si, input logic [3:0] rq);
      rst       = r;
      seed_load = sl;
      seed_in   = si;
      req       = rq;
      model_step(r, sl, si, rq);
      @(posedge clk);
      #1;
      check("gnt", 32'(gnt), 32'(m_gnt));
      check("rand_valid", 32'(rand_valid), 32'(m_valid));
      check("rand_out", 32'(rand_out), 32'(m_out));
      check("busy", 32'(busy), 32'(m_warm));
      check("nonzero", 32'(rand_valid && rand_out == 5'h00), 32'd0);
   endtask

   initial begin
      logic [3:0] exp_g [5];
      logic [4:0] exp_v [5];
      bit         seen [32];
      int         distinct;
      logic       prev2;

      rst = 1'b1; seed_load = 1'b0; seed_in = '0; req = '0;

      // Reset
      cyc(1, 0, 5'h00, 4'h0);
      check("reset_busy", 32'(busy), 32'd1);
      check("reset_gnt", 32'(gnt), 32'd0);
      check("reset_rand_out", 32'(rand_out), 32'd0);

      // T1: warm-up lasts exactly four steps
      for (int i = 0; i < 3; i++) cyc(0, 0, 5'h00, 4'h0);
      check("t1_busy_4th", 32'(busy), 32'd1);
      cyc(0, 0, 5'h00, 4'h0);
      check("t1_busy_5th", 32'(busy), 32'd0);

      // T2: single request gets LFSR state 5'h10
      cyc(0, 0, 5'h00, 4'b0001);
      check("t2_gnt", 32'(gnt), 32'b0001);
      check("t2_rand_out", 32'(rand_out), 32'h10);
      cyc(0, 0, 5'h00, 4'b0000);
      check("t2_no_regrant", 32'(gnt), 32'd0);

      // T3: all requesting from rr_ptr=0 after a fresh reset and warm-up
      cyc(1, 0, 5'h00, 4'h0);
      for (int i = 0; i < Warm; i++) cyc(0, 0, 5'h00, 4'h0);
      exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      exp_v = '{5'h10, 5'h05, 5'h0a, 5'h14, 5'h0d};
      for (int i = 0; i < 5; i++) begin
         cyc(0, 0, 5'h00, 4'b1111);
         check("t3_gnt", 32'(gnt), 32'(exp_g[i]));
         check("t3_rand_out", 32'(rand_out), 32'(exp_v[i]));
      end

      // T4: seed_load with zero seed beats a request
      cyc(0, 1, 5'h00, 4'b0010);
      check("t4_no_gnt", 32'(gnt), 32'd0);
      check("t4_busy", 32'(busy), 32'd1);
      for (int i = 0; i < Warm; i++) cyc(0, 0, 5'h00, 4'b0000);
      check("t4_busy_done", 32'(busy), 32'd0);
      cyc(0, 0, 5'h00, 4'b0010);
      check("t4_first_val", 32'(rand_out), 32'h10);

      // T5: lone held request is granted on alternate cycles
      prev2 = gnt[2];
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 5'h00, 4'b0100);
         check("t5_no_double", 32'(prev2 && gnt[2]), 32'd0);
         prev2 = gnt[2];
      end

      // T6: reset during back-to-back grants, then full period
      for (int i = 0; i < 3; i++) cyc(0, 0, 5'h00, 4'b1111);
      cyc(1, 0, 5'h00, 4'b1111);
      check("t6_gnt", 32'(gnt), 32'd0);
      check("t6_valid", 32'(rand_valid), 32'd0);
      check("t6_rand_out", 32'(rand_out), 32'd0);
      check("t6_busy", 32'(busy), 32'd1);
      for (int i = 0; i < Warm; i++) cyc(0, 0, 5'h00, 4'b1111);
      foreach (seen[i]) seen[i] = 0;
      distinct = 0;
      for (int i = 0; i < 31; i++) begin
         cyc(0, 0, 5'h00, 4'b1111);
         if (rand_valid && !seen[rand_out]) begin
            seen[rand_out] = 1;
            distinct++;
         end
      end
      check("t6_distinct", 32'(distinct), 32'd31);
      check("t6_zero_unseen", 32'(seen[0]), 32'd0);

      // Randomized traffic with occasional reseeds and resets
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 19) == 0),
             5'($urandom), 4'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
